// File: rtl/mc_control_unit.sv
// mc_control_unit: multi-cycle ARM-subset controller; sequences the datapath,
// holds the NZCV flag register and evaluates condition codes.
module mc_control_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instr,
  input  logic [3:0]  ALUFlags,
  output logic        PCWrite,
  output logic        RegWrite,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        AdrSrc,
  output logic        ALUSrcA,
  output logic        opMul,
  output logic [1:0]  RegSrc,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ImmSrc,
  output logic [2:0]  ALUControl,
  output logic [3:0]  State
);
  typedef enum logic [3:0] {
    FETCH, DECODE, EXECR, EXECI, ALUWB, MEMADR, MEMRD, MEMWB, MEMWR, BRANCH
  } state_t;
  state_t state, next;
  logic [3:0] flags, cmd, rd, cond;
  logic [1:0] op;
  logic [2:0] alu_cmd;
  logic i, s, l, is_mul, is_cmp, valid, nop, n, z, c, v, ge, r15;
  logic condex, cond_ok, pcw, rw, mw, irw, unused_bits;
  assign op = Instr[27:26];
  assign i = Instr[25];
  assign cmd = Instr[24:21];
  assign s = Instr[20];
  assign l = Instr[20];
  assign rd = Instr[15:12];
  assign cond = Instr[31:28];
  assign r15 = rd == 4'hf;
  assign unused_bits = ^{Instr[19:16], Instr[11:8], Instr[3:0]};
  assign is_mul = op == 2'b00 && !i && cmd == 4'b0000 && Instr[7:4] == 4'b1001;
  assign is_cmp = op == 2'b00 && cmd == 4'b1010;
  assign valid = cmd == 4'b0100 || cmd == 4'b0010 || cmd == 4'b0000 || cmd == 4'b1100 || cmd == 4'b1010;
  assign nop = op == 2'b11 || (op == 2'b00 && !valid);
  assign alu_cmd = is_mul ? 3'b100 :
                   cmd == 4'b0100 ? 3'b000 :
                   (cmd == 4'b0010 || cmd == 4'b1010) ? 3'b001 :
                   cmd == 4'b0000 ? 3'b010 :
                   cmd == 4'b1100 ? 3'b011 : 3'b000;
  assign {n, z, c, v} = flags;
  assign ge = n == v;
  always_comb begin
    case (cond)
      4'h0: cond_ok = z;
      4'h1: cond_ok = !z;
      4'h2: cond_ok = c;
      4'h3: cond_ok = !c;
      4'h4: cond_ok = n;
      4'h5: cond_ok = !n;
      4'h6: cond_ok = v;
      4'h7: cond_ok = !v;
      4'h8: cond_ok = c && !z;
      4'h9: cond_ok = !c || z;
      4'ha: cond_ok = ge;
      4'hb: cond_ok = !ge;
      4'hc: cond_ok = !z && ge;
      4'hd: cond_ok = z || !ge;
      4'he: cond_ok = 1'b1;
      default: cond_ok = 1'b0;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= FETCH;
      flags <= 4'b0000;
      condex <= 1'b0;
    end else begin
      state <= next;
      if (state == DECODE) condex <= cond_ok;
      // logical ops and MUL leave C and V untouched
      if ((state == EXECR || state == EXECI) && condex && (s || is_cmp))
        flags <= (alu_cmd[1] || alu_cmd[2]) ? {ALUFlags[3:2], flags[1:0]} : ALUFlags;
    end
  end
  always_comb begin
    next = FETCH;
    pcw = 1'b0;
    rw = 1'b0;
    mw = 1'b0;
    irw = 1'b0;
    AdrSrc = 1'b0;
    ALUSrcA = 1'b0;
    opMul = 1'b0;
    ALUSrcB = 2'b00;
    ResultSrc = 2'b00;
    ALUControl = 3'b000;
    case (state)
      FETCH: begin
        irw = 1'b1;
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ResultSrc = 2'b10;
        pcw = 1'b1;
        next = DECODE;
      end
      DECODE: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ResultSrc = 2'b10;
        next = (!cond_ok || nop) ? FETCH : op == 2'b01 ? MEMADR : op == 2'b10 ? BRANCH : i ? EXECI : EXECR;
      end
      EXECR, EXECI: begin
        ALUSrcB = state == EXECI ? 2'b01 : 2'b00;
        ALUControl = alu_cmd;
        opMul = is_mul;
        next = is_cmp ? FETCH : ALUWB;
      end
      ALUWB: begin
        rw = !r15;
        pcw = r15;
        opMul = is_mul;
      end
      MEMADR: begin
        ALUSrcB = 2'b01;
        next = l ? MEMRD : MEMWR;
      end
      MEMRD: begin
        AdrSrc = 1'b1;
        next = MEMWB;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        rw = !r15;
        pcw = r15;
      end
      MEMWR: begin
        AdrSrc = 1'b1;
        mw = 1'b1;
      end
      BRANCH: begin
        ALUSrcB = 2'b01;
        ResultSrc = 2'b10;
        pcw = 1'b1;
      end
      default: next = FETCH;
    endcase
  end
  // write enables are suppressed combinationally while reset is held
  assign PCWrite = pcw && reset;
  assign RegWrite = rw && reset;
  assign MemWrite = mw && reset;
  assign IRWrite = irw && reset;
  assign RegSrc = {op == 2'b01 && !l, op == 2'b10};
  assign ImmSrc = op;
  assign State = state;
endmodule

// File: tb/tb_mc_control_unit.sv
// tb_mc_control_unit: directed and random instruction streams checked against
// a per-instruction cycle-sequence model with its own flag register.
module tb_mc_control_unit;
  logic clk = 1'b0, reset = 1'b0;
  logic [31:0] Instr = 32'h0;
  logic [3:0] ALUFlags = 4'h0;
  logic PCWrite, RegWrite, MemWrite, IRWrite, AdrSrc, ALUSrcA, opMul;
  logic [1:0] RegSrc, ALUSrcB, ResultSrc, ImmSrc;
  logic [2:0] ALUControl;
  logic [3:0] State;
  logic [17:0] ctl;
  int errors = 0, checks = 0;
  logic [3:0] mflags = 4'h0;
  int seq[$];

  always #5 clk = ~clk;

  mc_control_unit dut (
    .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
    .PCWrite(PCWrite), .RegWrite(RegWrite), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .opMul(opMul), .RegSrc(RegSrc),
    .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ImmSrc(ImmSrc),
    .ALUControl(ALUControl), .State(State)
  );

  assign ctl = {PCWrite, RegWrite, MemWrite, IRWrite, AdrSrc, ALUSrcA, opMul,
                RegSrc, ALUSrcB, ResultSrc, ImmSrc, ALUControl};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ARM-style: even codes name a base test, odd codes invert it
  function automatic bit cond_holds(input logic [3:0] cc, input logic [3:0] f);
    bit base;
    case (cc[3:1])
      3'd0: base = f[2];
      3'd1: base = f[1];
      3'd2: base = f[3];
      3'd3: base = f[0];
      3'd4: base = f[1] && !f[2];
      3'd5: base = f[3] == f[0];
      3'd6: base = !f[2] && (f[3] == f[0]);
      default: base = 1'b1;
    endcase
    return cc == 4'hf ? 1'b0 : base ^ cc[0];
  endfunction

  function automatic bit is_mul(input logic [31:0] ins);
    return ins[27:25] == 3'b000 && ins[24:21] == 4'd0 && ins[7:4] == 4'b1001;
  endfunction

  function automatic int alu_code(input logic [31:0] ins);
    if (is_mul(ins)) return 4;
    case (ins[24:21])
      4'b0100: return 0;
      4'b0010, 4'b1010: return 1;
      4'b0000: return 2;
      4'b1100: return 3;
      default: return -1;
    endcase
  endfunction

  function automatic logic [17:0] exp_ctl(input int st, input logic [31:0] ins);
    logic pcw, rw, mw, irw, adr, sa, om;
    logic [1:0] sb, rs, op;
    logic [2:0] ac;
    bit r15;
    {pcw, rw, mw, irw, adr, sa, om} = 7'b0;
    sb = 2'b00; rs = 2'b00; ac = 3'b000;
    op = ins[27:26];
    r15 = ins[15:12] == 4'hf;
    case (st)
      0: begin irw = 1; sa = 1; sb = 2'b10; rs = 2'b10; pcw = 1; end
      1: begin sa = 1; sb = 2'b10; rs = 2'b10; end
      2, 3: begin sb = st == 3 ? 2'b01 : 2'b00; ac = 3'(alu_code(ins)); om = is_mul(ins); end
      4: begin rw = !r15; pcw = r15; om = is_mul(ins); end
      5: sb = 2'b01;
      6: adr = 1;
      7: begin rs = 2'b01; rw = !r15; pcw = r15; end
      8: begin adr = 1; mw = 1; end
      9: begin sb = 2'b01; rs = 2'b10; pcw = 1; end
      default: ;
    endcase
    return {pcw, rw, mw, irw, adr, sa, om, op == 2'b01 && !ins[20], op == 2'b10, sb, rs, op, ac};
  endfunction

  task automatic plan(input logic [31:0] ins);
    logic [1:0] op;
    op = ins[27:26];
    seq = {0, 1};
    if (!cond_holds(ins[31:28], mflags)) return;
    case (op)
      2'b01: seq = ins[20] ? {0, 1, 5, 6, 7} : {0, 1, 5, 8};
      2'b10: seq = {0, 1, 9};
      2'b00: if (alu_code(ins) >= 0) begin
        seq.push_back(ins[25] ? 3 : 2);
        if (ins[24:21] != 4'b1010) seq.push_back(4);
      end
      default: ;
    endcase
  endtask

  task automatic run(input logic [31:0] ins, input logic [3:0] af, input string tag);
    plan(ins);
    Instr = ins;
    ALUFlags = af;
    foreach (seq[k]) begin
      @(negedge clk);
      check($sformatf("%s state c%0d", tag, k), 32'(State), 32'(seq[k]));
      check($sformatf("%s ctl s%0d", tag, seq[k]), 32'(ctl), 32'(exp_ctl(seq[k], ins)));
      if ((seq[k] == 2 || seq[k] == 3) && (ins[20] || ins[24:21] == 4'b1010))
        mflags = alu_code(ins) >= 2 ? {af[3:2], mflags[1:0]} : af;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [31:0] ins;
    logic [3:0] cnd, cmd;
    repeat (3) begin
      @(negedge clk);
      check("rst state", 32'(State), 32'd0);
      check("rst we", 32'({PCWrite, RegWrite, MemWrite, IRWrite}), 32'd0);
    end
    @(posedge clk);
    #1 reset = 1'b1;
    mflags = 4'h0;
    run(32'h0A000002, 4'h0, "beq_flags0");
    run(32'hE2821005, 4'h0, "add_imm");
    run(32'hE5903004, 4'h0, "ldr");
    run(32'hE5803004, 4'h0, "str");
    run(32'hE1510001, 4'b0100, "cmp");
    run(32'h0A000002, 4'h0, "beq");
    run(32'h1A000002, 4'h0, "bne");
    run(32'hE0040392, 4'h0, "mul");
    run(32'hE282F005, 4'h0, "add_pc");
    run(32'hEC000000, 4'h0, "op11");
    run(32'hE1A00000, 4'h0, "badcmd");
    run(32'hE1510001, 4'b0100, "cmp2");
    Instr = 32'hE5803004;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("strrst state c%0d", k), 32'(State), 32'(k == 0 ? 0 : k == 1 ? 1 : 5));
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    @(negedge clk);
    check("strrst state8", 32'(State), 32'd8);
    check("strrst memwrite", 32'(MemWrite), 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    mflags = 4'h0;
    #3 check("strrst after", 32'(State), 32'd0);
    run(32'h0A000002, 4'h0, "beq_postrst");
    for (int t = 0; t < 300; t++) begin
      cnd = $urandom_range(0, 3) == 0 ? 4'he : 4'($urandom_range(0, 15));
      case ($urandom_range(0, 7))
        0, 1, 2: begin
          case ($urandom_range(0, 5))
            0: cmd = 4'b0100;
            1: cmd = 4'b0010;
            2: cmd = 4'b0000;
            3: cmd = 4'b1100;
            4: cmd = 4'b1010;
            default: cmd = 4'($urandom);
          endcase
          ins = {cnd, 2'b00, 1'($urandom), cmd, 1'($urandom), 4'($urandom), 4'($urandom), 12'($urandom)};
        end
        3: ins = {cnd, 7'b0000000, 1'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 4'b1001, 4'($urandom)};
        4, 5: ins = {cnd, 2'b01, 6'($urandom), 4'($urandom), 4'($urandom), 12'($urandom)};
        6: ins = {cnd, 2'b10, 26'($urandom)};
        default: ins = {cnd, 2'b11, 26'($urandom)};
      endcase
      run(ins, 4'($urandom), $sformatf("rnd%0d", t));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
